// File: rtl/bus_control_sequencer_if.sv
// Bus/handshake bundle between the control sequencer (master) and the datapath/memory (slave).
// Field names follow the datapath's control-signal naming.
interface bus_control_sequencer_if;
   logic        run;
   logic [31:0] ir;
   logic        mem_ready;

   logic [15:0] R_out;
   logic [15:0] R_in;
   logic        HIout;
   logic        LOout;
   logic        ZHIout;
   logic        ZLOout;
   logic        PCout;
   logic        MDRout;
   logic        CSignout;
   logic        HIin;
   logic        LOin;
   logic        Zin;
   logic        Yin;
   logic        PCin;
   logic        MARin;
   logic        MDRin;
   logic        IRin;
   logic        IncPC;
   logic        Read;
   logic        Write;
   logic [4:0]  alu_op;
   logic        halted;
   logic        illegal;

   modport master (
      input  run, ir, mem_ready,
      output R_out, R_in, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, CSignout,
      output HIin, LOin, Zin, Yin, PCin, MARin, MDRin, IRin, IncPC,
      output Read, Write, alu_op, halted, illegal
   );

   modport slave (
      output run, ir, mem_ready,
      input  R_out, R_in, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, CSignout,
      input  HIin, LOin, Zin, Yin, PCin, MARin, MDRin, IRin, IncPC,
      input  Read, Write, alu_op, halted, illegal
   );
endinterface

// File: rtl/bus_control_sequencer.sv
// Control-step sequencer: walks IDLE/T0..T7/HALT and decodes per-step bus source and load
// strobes from the step and the IR opcode/register fields.
module bus_control_sequencer (
   input logic                     clock,
   input logic                     reset,
   bus_control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
   } state_e;

   typedef enum logic [3:0] {
      ClsLd, ClsSt, ClsAlu, ClsImm, ClsMulDiv, ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
   } cls_e;

   localparam logic [4:0] OpAdd = 5'b00011;

   state_e      state_q, state_d;
   logic        wait_q, wait_d;
   cls_e        cls;
   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   logic [15:0] ra_oh, rb_oh, rc_oh;

   assign opcode = bus.ir[31:27];
   assign ra     = bus.ir[26:23];
   assign rb     = bus.ir[22:19];
   assign rc     = bus.ir[18:15];
   assign ra_oh  = 16'd1 << ra;
   assign rb_oh  = 16'd1 << rb;
   assign rc_oh  = 16'd1 << rc;

   always_comb begin
      cls = ClsIllegal;
      case (opcode)
         5'b00000:                            cls = ClsLd;
         5'b00001:                            cls = ClsSt;
         5'b00011, 5'b00100, 5'b00101, 5'b00110: cls = ClsAlu;
         5'b01100, 5'b01101, 5'b01110:        cls = ClsImm;
         5'b01111, 5'b10000:                  cls = ClsMulDiv;
         5'b10001:                            cls = ClsMfhi;
         5'b10010:                            cls = ClsMflo;
         5'b11010:                            cls = ClsNop;
         5'b11011:                            cls = ClsHalt;
         default:                             cls = ClsIllegal;
      endcase
   end

   // wait_d marks that the next cycle repeats the current step (memory not ready yet).
   always_comb begin
      state_d = state_q;
      wait_d  = 1'b0;
      unique case (state_q)
         StIdle: if (bus.run) state_d = StT0;
         StT0:   state_d = StT1;
         StT1: begin
            if (bus.mem_ready) state_d = StT2;
            else               wait_d  = 1'b1;
         end
         StT2:   state_d = StT3;
         StT3: begin
            unique case (cls)
               ClsLd, ClsSt, ClsAlu, ClsImm, ClsMulDiv: state_d = StT4;
               ClsHalt:                                 state_d = StHalt;
               default:                                 state_d = StT0;
            endcase
         end
         StT4:   state_d = StT5;
         StT5: begin
            if (cls == ClsLd || cls == ClsSt || cls == ClsMulDiv) state_d = StT6;
            else                                                   state_d = StT0;
         end
         StT6: begin
            if (cls == ClsLd) begin
               if (bus.mem_ready) state_d = StT7;
               else               wait_d  = 1'b1;
            end else if (cls == ClsSt) begin
               state_d = StT7;
            end else begin
               state_d = StT0;
            end
         end
         StT7: begin
            if (cls == ClsSt && !bus.mem_ready) wait_d  = 1'b1;
            else                                state_d = StT0;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         wait_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      bus.R_out    = '0;
      bus.R_in     = '0;
      bus.HIout    = 1'b0;
      bus.LOout    = 1'b0;
      bus.ZHIout   = 1'b0;
      bus.ZLOout   = 1'b0;
      bus.PCout    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.CSignout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.Zin      = 1'b0;
      bus.Yin      = 1'b0;
      bus.PCin     = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.IRin     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.Read     = 1'b0;
      bus.Write    = 1'b0;
      bus.alu_op   = '0;
      bus.halted   = 1'b0;
      bus.illegal  = 1'b0;
      unique case (state_q)
         StT0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
         end
         StT1: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            // PC update happens once, not on every wait cycle.
            if (!wait_q) begin
               bus.ZLOout = 1'b1;
               bus.PCin   = 1'b1;
            end
         end
         StT2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         StT3: begin
            unique case (cls)
               ClsLd, ClsSt, ClsAlu, ClsImm: begin
                  bus.R_out = rb_oh;
                  bus.Yin   = 1'b1;
               end
               ClsMulDiv: begin
                  bus.R_out = ra_oh;
                  bus.Yin   = 1'b1;
               end
               ClsMfhi: begin
                  bus.HIout = 1'b1;
                  bus.R_in  = ra_oh;
               end
               ClsMflo: begin
                  bus.LOout = 1'b1;
                  bus.R_in  = ra_oh;
               end
               ClsIllegal: bus.illegal = 1'b1;
               default: ;
            endcase
         end
         StT4: begin
            bus.Zin = 1'b1;
            unique case (cls)
               ClsLd, ClsSt: begin
                  bus.CSignout = 1'b1;
                  bus.alu_op   = OpAdd;
               end
               ClsAlu: begin
                  bus.R_out  = rc_oh;
                  bus.alu_op = opcode;
               end
               ClsImm: begin
                  bus.CSignout = 1'b1;
                  bus.alu_op   = opcode;
               end
               ClsMulDiv: begin
                  bus.R_out  = rb_oh;
                  bus.alu_op = opcode;
               end
               default: bus.Zin = 1'b0;
            endcase
         end
         StT5: begin
            unique case (cls)
               ClsLd, ClsSt: begin
                  bus.ZLOout = 1'b1;
                  bus.MARin  = 1'b1;
               end
               ClsAlu, ClsImm: begin
                  bus.ZLOout = 1'b1;
                  bus.R_in   = ra_oh;
               end
               ClsMulDiv: begin
                  bus.ZLOout = 1'b1;
                  bus.LOin   = 1'b1;
               end
               default: ;
            endcase
         end
         StT6: begin
            unique case (cls)
               ClsLd: begin
                  bus.Read  = 1'b1;
                  bus.MDRin = 1'b1;
               end
               ClsSt: begin
                  bus.R_out = ra_oh;
                  bus.MDRin = 1'b1;
               end
               ClsMulDiv: begin
                  bus.ZHIout = 1'b1;
                  bus.HIin   = 1'b1;
               end
               default: ;
            endcase
         end
         StT7: begin
            unique case (cls)
               ClsLd: begin
                  bus.MDRout = 1'b1;
                  bus.R_in   = ra_oh;
               end
               ClsSt: bus.Write = 1'b1;
               default: ;
            endcase
         end
         StHalt: bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Directed bench for bus_control_sequencer: per-cycle vector table, cycle-count and corner
// sequences, and a random stream checking the single-source and Read/Write exclusion rules.
module tb_bus_control_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_control_sequencer_if bus_if ();

   bus_control_sequencer dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus_if.master)
   );

   // Strobe bit positions in the packed control word.
   localparam logic [19:0] HIOUT = 20'h1 << 0,  LOOUT = 20'h1 << 1,  ZHIOUT = 20'h1 << 2;
   localparam logic [19:0] ZLOOUT = 20'h1 << 3, PCOUT = 20'h1 << 4,  MDROUT = 20'h1 << 5;
   localparam logic [19:0] CSIGN = 20'h1 << 6,  HIIN = 20'h1 << 7,   LOIN = 20'h1 << 8;
   localparam logic [19:0] ZIN = 20'h1 << 9,    YIN = 20'h1 << 10,   PCIN = 20'h1 << 11;
   localparam logic [19:0] MARIN = 20'h1 << 12, MDRIN = 20'h1 << 13, IRIN = 20'h1 << 14;
   localparam logic [19:0] INCPC = 20'h1 << 15, READ = 20'h1 << 16,  WRITE = 20'h1 << 17;
   localparam logic [19:0] HALTED = 20'h1 << 18, ILLEGAL = 20'h1 << 19;
   localparam logic [19:0] F0 = PCOUT | MARIN | INCPC | ZIN;
   localparam logic [19:0] F1 = ZLOOUT | PCIN | READ | MDRIN;
   localparam logic [19:0] F2 = MDROUT | IRIN;

   typedef struct {
      bit          rst;
      bit          run;
      bit          mr;
      logic [31:0] ir;
      logic [15:0] rout;
      logic [15:0] rin;
      logic [4:0]  alu;
      logic [19:0] ctl;
      string       name;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
      logic [4:0] o = 5'(op);
      logic [3:0] a = 4'(ra);
      logic [3:0] b = 4'(rb);
      logic [3:0] c = 4'(rc);
      return {o, a, b, c, 15'd0};
   endfunction

   function automatic vec_t v(input bit r, input bit rn, input bit m, input logic [31:0] iw,
                              input logic [15:0] ro, input logic [15:0] ri,
                              input logic [4:0] al, input logic [19:0] c, input string nm);
      vec_t t;
      t.rst = r; t.run = rn; t.mr = m; t.ir = iw;
      t.rout = ro; t.rin = ri; t.alu = al; t.ctl = c; t.name = nm;
      return t;
   endfunction

   function automatic logic [19:0] act_ctl();
      return {bus_if.illegal, bus_if.halted, bus_if.Write, bus_if.Read, bus_if.IncPC,
              bus_if.IRin, bus_if.MDRin, bus_if.MARin, bus_if.PCin, bus_if.Yin, bus_if.Zin,
              bus_if.LOin, bus_if.HIin, bus_if.CSignout, bus_if.MDRout, bus_if.PCout,
              bus_if.ZLOout, bus_if.ZHIout, bus_if.LOout, bus_if.HIout};
   endfunction

   function automatic logic [63:0] act_all();
      return {7'd0, bus_if.R_out, bus_if.R_in, bus_if.alu_op, act_ctl()};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fetch(input logic [31:0] iw, input string tag);
      tbl.push_back(v(0, 0, 1, iw, 0, 0, 0, F0, {tag, "_t0"}));
      tbl.push_back(v(0, 0, 1, iw, 0, 0, 0, F1, {tag, "_t1"}));
      tbl.push_back(v(0, 0, 1, iw, 0, 0, 0, F2, {tag, "_t2"}));
   endtask

   // From any state: reset, then run, leaving the DUT in T0.
   task automatic go_t0();
      rst = 1'b1; bus_if.run = 1'b0;
      tick();
      rst = 1'b0; bus_if.run = 1'b1;
      tick();
      bus_if.run = 1'b0;
   endtask

   // Starting in T0, run one instruction; each memory wait gets `waits` not-ready cycles.
   task automatic run_instr(input logic [31:0] iw, input int waits, input int exp_cyc,
                            input int exp_reads, input string nm);
      int n = 0, w = 0, pcins = 0, reads = 0;
      bus_if.ir = iw;
      for (int c = 0; c < 40; c++) begin
         if ((bus_if.Read || bus_if.Write) && w < waits) begin
            bus_if.mem_ready = 1'b0;
            w++;
         end else begin
            bus_if.mem_ready = 1'b1;
            w = 0;
         end
         pcins += int'(bus_if.PCin);
         reads += int'(bus_if.Read);
         n++;
         tick();
         if (bus_if.PCout && bus_if.MARin) break;
      end
      check({nm, "_cycles"}, 64'(n), 64'(exp_cyc));
      check({nm, "_pcin"}, 64'(pcins), 64'd1);
      check({nm, "_reads"}, 64'(reads), 64'(exp_reads));
   endtask

   localparam logic [31:0] IR_ADD  = 32'h191B_0000;  // add Ra=2 Rb=3 Rc=6
   localparam logic [31:0] IR_MUL  = 32'h7910_0000;  // mul Ra=2 Rb=2
   localparam logic [31:0] IR_HALT = 32'hD800_0000;

   initial begin
      logic [31:0] ir_ld, ir_st, ir_mfhi, ir_mflo, ir_addi, ir_nop;
      int bad, viol_src, viol_rw;
      int ops[18] = '{0, 1, 3, 4, 5, 6, 12, 13, 14, 15, 16, 17, 18, 26, 27, 31, 2, 7};
      ir_ld   = mk(0, 3, 4, 0);
      ir_st   = mk(1, 5, 7, 0);
      ir_mfhi = mk(17, 9, 0, 0);
      ir_mflo = mk(18, 4, 0, 0);
      ir_addi = mk(12, 1, 8, 0);
      ir_nop  = mk(26, 0, 0, 0);

      tbl.push_back(v(0, 0, 1, IR_ADD, 0, 0, 0, 0, "idle_after_reset"));
      tbl.push_back(v(0, 1, 1, IR_ADD, 0, 0, 0, 0, "idle_run"));
      push_fetch(IR_ADD, "add");
      tbl.push_back(v(0, 0, 1, IR_ADD, 16'h0008, 0, 0, YIN, "add_t3"));
      tbl.push_back(v(0, 0, 1, IR_ADD, 16'h0040, 0, 5'd3, ZIN, "add_t4"));
      tbl.push_back(v(0, 0, 1, IR_ADD, 0, 16'h0004, 0, ZLOOUT, "add_t5"));
      push_fetch(IR_MUL, "mul");
      tbl.push_back(v(0, 0, 1, IR_MUL, 16'h0004, 0, 0, YIN, "mul_t3"));
      tbl.push_back(v(0, 0, 1, IR_MUL, 16'h0004, 0, 5'd15, ZIN, "mul_t4"));
      tbl.push_back(v(0, 0, 1, IR_MUL, 0, 0, 0, ZLOOUT | LOIN, "mul_t5"));
      tbl.push_back(v(0, 0, 1, IR_MUL, 0, 0, 0, ZHIOUT | HIIN, "mul_t6"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 0, 0, F0, "ld_t0"));
      tbl.push_back(v(0, 0, 0, ir_ld, 0, 0, 0, F1, "ld_t1"));
      tbl.push_back(v(0, 0, 0, ir_ld, 0, 0, 0, READ | MDRIN, "ld_t1_w1"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 0, 0, READ | MDRIN, "ld_t1_w2"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 0, 0, F2, "ld_t2"));
      tbl.push_back(v(0, 0, 1, ir_ld, 16'h0010, 0, 0, YIN, "ld_t3"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 0, 5'd3, CSIGN | ZIN, "ld_t4"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 0, 0, ZLOOUT | MARIN, "ld_t5"));
      tbl.push_back(v(0, 0, 0, ir_ld, 0, 0, 0, READ | MDRIN, "ld_t6"));
      tbl.push_back(v(0, 0, 0, ir_ld, 0, 0, 0, READ | MDRIN, "ld_t6_w1"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 0, 0, READ | MDRIN, "ld_t6_w2"));
      tbl.push_back(v(0, 0, 1, ir_ld, 0, 16'h0008, 0, MDROUT, "ld_t7"));
      push_fetch(ir_st, "st");
      tbl.push_back(v(0, 0, 1, ir_st, 16'h0080, 0, 0, YIN, "st_t3"));
      tbl.push_back(v(0, 0, 1, ir_st, 0, 0, 5'd3, CSIGN | ZIN, "st_t4"));
      tbl.push_back(v(0, 0, 1, ir_st, 0, 0, 0, ZLOOUT | MARIN, "st_t5"));
      tbl.push_back(v(0, 0, 1, ir_st, 16'h0020, 0, 0, MDRIN, "st_t6"));
      tbl.push_back(v(0, 0, 0, ir_st, 0, 0, 0, WRITE, "st_t7"));
      tbl.push_back(v(0, 0, 1, ir_st, 0, 0, 0, WRITE, "st_t7_w1"));
      push_fetch(ir_mfhi, "mfhi");
      tbl.push_back(v(0, 0, 1, ir_mfhi, 0, 16'h0200, 0, HIOUT, "mfhi_t3"));
      push_fetch(ir_mflo, "mflo");
      tbl.push_back(v(0, 0, 1, ir_mflo, 0, 16'h0010, 0, LOOUT, "mflo_t3"));
      push_fetch(ir_addi, "addi");
      tbl.push_back(v(0, 0, 1, ir_addi, 16'h0100, 0, 0, YIN, "addi_t3"));
      tbl.push_back(v(0, 0, 1, ir_addi, 0, 0, 5'd12, CSIGN | ZIN, "addi_t4"));
      tbl.push_back(v(0, 0, 1, ir_addi, 0, 16'h0002, 0, ZLOOUT, "addi_t5"));
      tbl.push_back(v(1, 1, 1, ir_addi, 0, 0, 0, F0, "reset_at_t0"));
      tbl.push_back(v(0, 0, 1, ir_addi, 0, 0, 0, 0, "idle_after_t0_reset"));

      rst = 1'b1; bus_if.run = 1'b0; bus_if.mem_ready = 1'b0; bus_if.ir = '0;
      tick();
      tick();
      foreach (tbl[i]) begin
         rst = tbl[i].rst; bus_if.run = tbl[i].run;
         bus_if.mem_ready = tbl[i].mr; bus_if.ir = tbl[i].ir;
         #1;
         check(tbl[i].name, act_all(),
               {7'd0, tbl[i].rout, tbl[i].rin, tbl[i].alu, tbl[i].ctl});
         tick();
      end

      // Instruction lengths, including memory waits.
      go_t0();
      run_instr(IR_ADD, 0, 6, 1, "len_add");
      run_instr(ir_ld, 0, 8, 2, "len_ld");
      run_instr(ir_ld, 2, 12, 6, "len_ld_wait2");
      run_instr(ir_st, 0, 8, 1, "len_st");
      run_instr(ir_st, 1, 10, 2, "len_st_wait1");
      run_instr(IR_MUL, 0, 7, 1, "len_mul");
      run_instr(ir_addi, 0, 6, 1, "len_addi");
      run_instr(ir_mfhi, 0, 4, 1, "len_mfhi");
      run_instr(ir_nop, 0, 4, 1, "len_nop");

      // Reset while ld is waiting in T6.
      go_t0();
      bus_if.ir = ir_ld; bus_if.mem_ready = 1'b1;
      repeat (6) tick();
      bus_if.mem_ready = 1'b0;
      check("ld_t6_before_reset", 64'(act_ctl()), 64'(READ | MDRIN));
      tick();
      check("ld_t6_still_waiting", 64'(act_ctl()), 64'(READ | MDRIN));
      rst = 1'b1;
      tick();
      rst = 1'b0; bus_if.run = 1'b1;
      check("reset_mid_wait", act_all(), 64'd0);
      tick();
      bus_if.run = 1'b0;
      check("restart_t0", act_all(), 64'(F0));

      // halt is sticky until reset, even with run held high.
      go_t0();
      bus_if.ir = IR_HALT; bus_if.mem_ready = 1'b1;
      repeat (3) tick();
      check("halt_t3", act_all(), 64'd0);
      tick();
      check("halt_entered", act_all(), 64'(HALTED));
      bus_if.run = 1'b1;
      bad = 0;
      repeat (5) begin
         tick();
         if (act_all() !== 64'(HALTED)) bad++;
      end
      check("halt_holds_with_run", 64'(bad), 64'd0);
      rst = 1'b1; bus_if.run = 1'b0;
      tick();
      rst = 1'b0;
      check("halt_cleared_by_reset", act_all(), 64'd0);

      // Undefined opcode: one illegal pulse, no strobes, back to T0.
      go_t0();
      bus_if.ir = mk(31, 1, 2, 3);
      repeat (3) tick();
      check("illegal_t3", act_all(), 64'(ILLEGAL));
      tick();
      check("illegal_back_t0", act_all(), 64'(F0));

      // Random opcodes and memory latency.
      go_t0();
      viol_src = 0; viol_rw = 0;
      for (int c = 0; c < 10000; c++) begin
         rst = bus_if.halted;
         if (bus_if.PCout && bus_if.MARin)
            bus_if.ir = mk(ops[$urandom_range(0, 17)], int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         bus_if.run = 1'b1;
         bus_if.mem_ready = 1'($urandom_range(0, 1));
         #1;
         if ($countones({bus_if.R_out, bus_if.HIout, bus_if.LOout, bus_if.ZHIout,
                         bus_if.ZLOout, bus_if.PCout, bus_if.MDRout, bus_if.CSignout}) > 1)
            viol_src++;
         if (bus_if.Read && bus_if.Write) viol_rw++;
         tick();
      end
      check("rand_single_source", 64'(viol_src), 64'd0);
      check("rand_read_write_excl", 64'(viol_rw), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
